// File: rtl/calc_pkg.sv
`timescale 1ns/1ps
// calc_pkg: shared definitions for the calculator keypad front end.
//   - Key codes for the operator/control keys (digits use their own value).
//   - Scanner FSM state encoding.
//   - low_row(): lowest-index active-low row of a 4-bit row vector.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_ENT = 4'd15;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  // Rows are active-low; row 0 has priority when several are pulled low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
`timescale 1ns/1ps
// keypad_keymap: combinational 4x4 keypad position to key code.
//   row  in  [1:0]  keypad row index
//   col  in  [1:0]  keypad column index
//   code out [3:0]  key code (digits 0..9, A/B/C/D = 10..13, * = 14, # = 15)
module keypad_keymap
  import calc_pkg::*;
(
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] code
);

  always_comb begin
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_ENT;
      4'b11_11: code = KEY_DIV;
      default:  code = 4'd0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
//   clk       in        system clock
//   rst       in        asynchronous active-high reset
//   row_in    in  [3:0] keypad rows, active-low, asynchronous to clk
//   col_out   out [3:0] column drive, active-low, one-hot low
//   key_code  out [3:0] code of the last accepted key
//   key_valid out       one-cycle strobe per accepted press
//   key_held  out       high until the release of the accepted key is debounced
//
// state    | meaning
// SCAN     | walking columns, looking for any low row on each tick
// DEBOUNCE | column frozen, counting ticks with the detected row low
// PRESSED  | key accepted, counting consecutive ticks with the row high
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    row_meta;
  logic [3:0]    rows_s;
  scan_state_t   state;
  logic [1:0]    col_idx;
  logic [1:0]    key_row;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    map_code;
  logic          deb_last;

  assign tick     = (tick_cnt == TW'(SCAN_DIV - 1));
  assign deb_last = (deb_cnt == DW'(DEBOUNCE_TICKS - 1));
  assign col_out  = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TW'(1);
  end

  // Idle rows read high, so the synchronizer resets to "no key".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      rows_s   <= 4'hF;
    end else begin
      row_meta <= row_in;
      rows_s   <= row_meta;
    end
  end

  keypad_keymap u_keymap (
    .row  (key_row),
    .col  (col_idx),
    .code (map_code)
  );

  // Counter compares against DEBOUNCE_TICKS-1 before incrementing so the
  // accept/release action lands on the tick that makes the count complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      key_row   <= 2'd0;
      deb_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (rows_s != 4'hF) begin
              key_row <= low_row(rows_s);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (!rows_s[key_row]) begin
              if (deb_last) begin
                key_code  <= map_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                state     <= PRESSED;
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_idx + 2'd1;
            end
          end
          PRESSED: begin
            if (rows_s[key_row]) begin
              if (deb_last) begin
                key_held <= 1'b0;
                deb_cnt  <= '0;
                state    <= SCAN;
                col_idx  <= col_idx + 2'd1;
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
              end
            end else begin
              deb_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// tb_keypad_scanner: directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_TICKS=3).
// A keypad model pulls a row low while its pressed key's column is driven low.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = 16'h0;       // bit r*4+c = key at row r, column c is down
  logic [3:0]  force_low = 4'h0;   // rows pulled low regardless of column

  int total = 0;
  int bad   = 0;
  int edges = 0;                   // posedges since reset release
  int pulses = 0;
  logic [3:0] last_code = 4'h0;
  logic       held_at_strobe = 1'b0;
  logic [3:0] col_at_strobe = 4'h0;

  logic [1:0] km_row = 2'd0;
  logic [1:0] km_col = 2'd0;
  logic [3:0] km_code;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  keypad_keymap u_km (
    .row  (km_row),
    .col  (km_col),
    .code (km_code)
  );

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    row_in = row_in & ~force_low;
  end

  always @(posedge clk) begin
    if (rst) edges <= 0;
    else edges <= edges + 1;
  end

  task automatic step();
    @(negedge clk);
    if (key_valid) begin
      pulses++;
      last_code      = key_code;
      held_at_strobe = key_held;
      col_at_strobe  = col_out;
    end
  endtask

  // Advance to the negedge right after a scan tick edge.
  task automatic align();
    do step(); while (edges % 4 != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", col_out); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b exp=0", key_held); end
    rst = 1'b0;
  endtask

  task automatic test_keymap();
    logic [3:0] exp_map [16];
    exp_map = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};
    for (int i = 0; i < 16; i++) begin
      km_row = 2'(i / 4);
      km_col = 2'(i % 4);
      #1;
      total++;
      if (km_code !== exp_map[i]) begin
        bad++; $display("FAIL keymap r%0d c%0d got=%0d exp=%0d", i / 4, i % 4, km_code, exp_map[i]);
      end
    end
  endtask

  task automatic test_idle();
    logic [3:0] exp_col;
    for (int i = 0; i < 20; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      total++;
      if (col_out !== exp_col || key_valid !== 1'b0 || key_held !== 1'b0) begin
        bad++; $display("FAIL idle_scan i=%0d col=%b exp=%b valid=%b held=%b", i, col_out, exp_col, key_valid, key_held);
      end
      step();
    end
  endtask

  task automatic test_press_5();
    int first;
    int n;
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (col_out == 4'b1101 && edges % 4 == 0) begin found = 1'b1; break; end
      step();
    end
    total++; if (!found) begin bad++; $display("FAIL press5_sync col1 window not seen"); end
    pulses = 0;
    first = -1;
    keys[1*4+1] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (pulses == 1 && first < 0) first = k;
    end
    total++; if (first != 15) begin bad++; $display("FAIL press5_latency got=%0d exp=15", first); end
    total++; if (pulses != 1) begin bad++; $display("FAIL press5_pulses got=%0d exp=1", pulses); end
    total++; if (last_code !== 4'd5) begin bad++; $display("FAIL press5_code got=%0d exp=5", last_code); end
    total++; if (held_at_strobe !== 1'b1) begin bad++; $display("FAIL press5_held_at_strobe got=%b exp=1", held_at_strobe); end
    total++; if (col_at_strobe !== 4'b1101) begin bad++; $display("FAIL press5_col_frozen got=%b exp=1101", col_at_strobe); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press5_held got=%b exp=1", key_held); end
    align();
    keys[1*4+1] = 1'b0;
    for (n = 0; n < 40; n++) begin
      step();
      if (!key_held) break;
    end
    total++; if (n != 11) begin bad++; $display("FAIL press5_release_delay got=%0d exp=11", n); end
    total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL press5_resume_col got=%b exp=1011", col_out); end
    repeat (8) step();
    total++; if (pulses != 1) begin bad++; $display("FAIL press5_single got=%0d exp=1", pulses); end
  endtask

  task automatic test_bounce();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (col_out == 4'b1110 && edges % 4 == 0) begin found = 1'b1; break; end
      step();
    end
    total++; if (!found) begin bad++; $display("FAIL bounce_sync col0 window not seen"); end
    pulses = 0;
    force_low = 4'b0100;
    repeat (4) step();
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL bounce_detect_col got=%b exp=1110", col_out); end
    force_low = 4'h0;
    repeat (4) step();
    total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL bounce_return_col got=%b exp=1101", col_out); end
    repeat (4) step();
    total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL bounce_scanning got=%b exp=1011", col_out); end
    total++; if (pulses != 0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
    total++; if (key_code !== 4'd5) begin bad++; $display("FAIL bounce_code_kept got=%0d exp=5", key_code); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held got=%b exp=0", key_held); end
  endtask

  task automatic test_multi_row();
    int n;
    pulses = 0;
    keys[1*4+3] = 1'b1;
    keys[2*4+3] = 1'b1;
    repeat (40) step();
    total++; if (pulses != 1) begin bad++; $display("FAIL multi_pulses got=%0d exp=1", pulses); end
    total++; if (last_code !== 4'd11) begin bad++; $display("FAIL multi_code got=%0d exp=11", last_code); end
    total++; if (col_at_strobe !== 4'b0111) begin bad++; $display("FAIL multi_col got=%b exp=0111", col_at_strobe); end
    align();
    keys = 16'h0;
    for (n = 0; n < 40; n++) begin
      step();
      if (!key_held) break;
    end
    total++; if (n != 11) begin bad++; $display("FAIL multi_release_delay got=%0d exp=11", n); end
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL multi_resume_col got=%b exp=1110", col_out); end
  endtask

  task automatic test_release_bounce();
    int n;
    int drops;
    pulses = 0;
    drops = 0;
    keys[3*4+2] = 1'b1;
    repeat (40) step();
    total++; if (pulses != 1) begin bad++; $display("FAIL hash_pulses got=%0d exp=1", pulses); end
    total++; if (last_code !== 4'd15) begin bad++; $display("FAIL hash_code got=%0d exp=15", last_code); end
    align();
    for (int t = 0; t < 4; t++) begin
      keys[3*4+2] = t[0];
      repeat (4) begin
        step();
        if (!key_held) drops++;
      end
    end
    total++; if (drops != 0) begin bad++; $display("FAIL hash_held_during_bounce low_samples=%0d exp=0", drops); end
    keys = 16'h0;
    for (n = 0; n < 40; n++) begin
      step();
      if (!key_held) break;
    end
    total++; if (n != 11) begin bad++; $display("FAIL hash_release_delay got=%0d exp=11", n); end
    repeat (8) step();
    total++; if (pulses != 1) begin bad++; $display("FAIL hash_single got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid();
    int n;
    pulses = 0;
    keys[0*4+3] = 1'b1;
    repeat (40) step();
    total++; if (pulses != 1 || last_code !== 4'd10) begin bad++; $display("FAIL rstmid_pre pulses=%0d code=%0d exp 1/10", pulses, last_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL rstmid_pre_held got=%b exp=1", key_held); end
    #2 rst = 1'b1;
    #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL rstmid_col got=%b exp=1110", col_out); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL rstmid_code got=%0d exp=0", key_code); end
    total++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL rstmid_flags held=%b valid=%b exp 0/0", key_held, key_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (60) step();
    total++; if (pulses != 1) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=1", pulses); end
    total++; if (last_code !== 4'd10) begin bad++; $display("FAIL rstmid_code_after got=%0d exp=10", last_code); end
    keys = 16'h0;
    for (n = 0; n < 40; n++) begin
      step();
      if (!key_held) break;
    end
    total++; if (n >= 40) begin bad++; $display("FAIL rstmid_release timeout held=%b", key_held); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_keymap();
    test_press_5();
    test_bounce();
    test_multi_row();
    test_release_bounce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
